// File: rtl/sc_equal_scan_ctrl_if.sv
// Signal bundle between the upstream control FSM / stream source / comparator
// (master side) and the equality scan sequencer (slave side).
interface sc_equal_scan_ctrl_if #(
    parameter int NUMBER_DATAWIDTH = 8,
    parameter int COUNT_WIDTH      = 4
);
    logic                        SC_EQSCAN_start_In;
    logic [NUMBER_DATAWIDTH-1:0] SC_EQSCAN_target_InBUS;
    logic [COUNT_WIDTH-1:0]      SC_EQSCAN_len_InBUS;
    logic                        SC_EQSCAN_valid_In;
    logic [NUMBER_DATAWIDTH-1:0] SC_EQSCAN_data_InBUS;
    logic                        SC_EQSCAN_ready_Out;
    logic [NUMBER_DATAWIDTH-1:0] SC_EQSCAN_cmpA_OutBUS;
    logic [NUMBER_DATAWIDTH-1:0] SC_EQSCAN_cmpB_OutBUS;
    logic                        SC_EQSCAN_cmpNotEqual_In;
    logic                        SC_EQSCAN_busy_Out;
    logic                        SC_EQSCAN_done_Out;
    logic                        SC_EQSCAN_found_Out;
    logic [COUNT_WIDTH-1:0]      SC_EQSCAN_firstIdx_OutBUS;
    logic [COUNT_WIDTH-1:0]      SC_EQSCAN_matchCount_OutBUS;

    modport master (
        output SC_EQSCAN_start_In,
        output SC_EQSCAN_target_InBUS,
        output SC_EQSCAN_len_InBUS,
        output SC_EQSCAN_valid_In,
        output SC_EQSCAN_data_InBUS,
        output SC_EQSCAN_cmpNotEqual_In,
        input  SC_EQSCAN_ready_Out,
        input  SC_EQSCAN_cmpA_OutBUS,
        input  SC_EQSCAN_cmpB_OutBUS,
        input  SC_EQSCAN_busy_Out,
        input  SC_EQSCAN_done_Out,
        input  SC_EQSCAN_found_Out,
        input  SC_EQSCAN_firstIdx_OutBUS,
        input  SC_EQSCAN_matchCount_OutBUS
    );

    modport slave (
        input  SC_EQSCAN_start_In,
        input  SC_EQSCAN_target_InBUS,
        input  SC_EQSCAN_len_InBUS,
        input  SC_EQSCAN_valid_In,
        input  SC_EQSCAN_data_InBUS,
        input  SC_EQSCAN_cmpNotEqual_In,
        output SC_EQSCAN_ready_Out,
        output SC_EQSCAN_cmpA_OutBUS,
        output SC_EQSCAN_cmpB_OutBUS,
        output SC_EQSCAN_busy_Out,
        output SC_EQSCAN_done_Out,
        output SC_EQSCAN_found_Out,
        output SC_EQSCAN_firstIdx_OutBUS,
        output SC_EQSCAN_matchCount_OutBUS
    );
endinterface

// File: rtl/sc_equal_scan_ctrl.sv
// Equality scan sequencer: streams words past a shared external comparator and
// tallies matches. Define SC_EQSCAN_STOP_ON_MATCH_EN to end the scan at the first match.
module sc_equal_scan_ctrl #(
    parameter int NUMBER_DATAWIDTH = 8,
    parameter int COUNT_WIDTH      = 4
) (
    input logic                 SC_EQSCAN_CLOCK_50,
    input logic                 SC_EQSCAN_RESET_InLow,
    sc_equal_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scanState_e;

    scanState_e state;
    scanState_e stateNext;

    logic [NUMBER_DATAWIDTH-1:0] targetReg;
    logic [NUMBER_DATAWIDTH-1:0] wordReg;
    logic [COUNT_WIDTH-1:0]      lenReg;
    logic [COUNT_WIDTH-1:0]      index;
    logic [COUNT_WIDTH-1:0]      pendTag;
    logic [COUNT_WIDTH-1:0]      firstIdx;
    logic [COUNT_WIDTH-1:0]      matchCount;
    logic                        pending;
    logic                        found;

    logic ready;
    logic accept;
    logic hit;
    logic firstHit;
    logic lastAccept;
    logic stopNow;

    // The comparator sees last cycle's accepted word, so its result belongs to pendTag.
    assign hit        = pending && !bus.SC_EQSCAN_cmpNotEqual_In;
    assign firstHit   = hit && !found;
    assign accept     = bus.SC_EQSCAN_valid_In && ready;
    assign lastAccept = accept && (index == lenReg - COUNT_WIDTH'(1));

`ifdef SC_EQSCAN_STOP_ON_MATCH_EN
    assign stopNow = (state == SCAN) && firstHit;
`else
    assign stopNow = 1'b0;
`endif

    assign ready = (state == SCAN) && !stopNow;

    always_ff @(posedge SC_EQSCAN_CLOCK_50 or negedge SC_EQSCAN_RESET_InLow) begin
        if (!SC_EQSCAN_RESET_InLow) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (bus.SC_EQSCAN_start_In) begin
                    stateNext = (bus.SC_EQSCAN_len_InBUS == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (stopNow) begin
                    stateNext = DONE;
                end else if (lastAccept) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Evaluation of word k and acceptance of word k+1 share a cycle for full throughput.
    always_ff @(posedge SC_EQSCAN_CLOCK_50 or negedge SC_EQSCAN_RESET_InLow) begin
        if (!SC_EQSCAN_RESET_InLow) begin
            targetReg  <= '0;
            wordReg    <= '0;
            lenReg     <= '0;
            index      <= '0;
            pendTag    <= '0;
            firstIdx   <= '0;
            matchCount <= '0;
            pending    <= 1'b0;
            found      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.SC_EQSCAN_start_In) begin
                        targetReg  <= bus.SC_EQSCAN_target_InBUS;
                        lenReg     <= bus.SC_EQSCAN_len_InBUS;
                        found      <= 1'b0;
                        firstIdx   <= '0;
                        matchCount <= '0;
                        index      <= '0;
                        pending    <= 1'b0;
                    end
                end
                SCAN, DRAIN: begin
                    if (hit) begin
                        matchCount <= matchCount + COUNT_WIDTH'(1);
                        if (!found) begin
                            found    <= 1'b1;
                            firstIdx <= pendTag;
                        end
                    end
                    if (accept) begin
                        wordReg <= bus.SC_EQSCAN_data_InBUS;
                        pendTag <= index;
                        index   <= index + COUNT_WIDTH'(1);
                    end
                    pending <= accept;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.SC_EQSCAN_ready_Out         = ready;
    assign bus.SC_EQSCAN_cmpA_OutBUS       = targetReg;
    assign bus.SC_EQSCAN_cmpB_OutBUS       = wordReg;
    assign bus.SC_EQSCAN_busy_Out          = (state != IDLE);
    assign bus.SC_EQSCAN_done_Out          = (state == DONE);
    assign bus.SC_EQSCAN_found_Out         = found;
    assign bus.SC_EQSCAN_firstIdx_OutBUS   = firstIdx;
    assign bus.SC_EQSCAN_matchCount_OutBUS = matchCount;

endmodule

// File: tb/tb_sc_equal_scan_ctrl.sv
// Self-checking bench for sc_equal_scan_ctrl: directed scenarios plus random scans
// compared against a list-level model of match count / first index / consumption.
module tb_sc_equal_scan_ctrl;

    localparam int DW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rstN;

    int checkCount = 0;
    int failCount  = 0;

    logic [DW-1:0] stimWords[$];

    always #10 clk = ~clk;

    sc_equal_scan_ctrl_if #(.NUMBER_DATAWIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    sc_equal_scan_ctrl #(.NUMBER_DATAWIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .SC_EQSCAN_CLOCK_50    (clk),
        .SC_EQSCAN_RESET_InLow (rstN),
        .bus                   (bus)
    );

    // External combinational comparator shared by the sequencer.
    assign bus.SC_EQSCAN_cmpNotEqual_In = (bus.SC_EQSCAN_cmpA_OutBUS != bus.SC_EQSCAN_cmpB_OutBUS);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: scan the word list directly for equality with the target.
    task automatic modelScan(input logic [DW-1:0] tgt, input int scanLen,
                             output bit expFound, output int expFirst,
                             output int expCount, output int expConsumed);
        expFound    = 1'b0;
        expFirst    = 0;
        expCount    = 0;
        expConsumed = scanLen;
        for (int i = 0; i < scanLen; i++) begin
            if (stimWords[i] == tgt) begin
                expCount++;
                if (!expFound) begin
                    expFound = 1'b1;
                    expFirst = i;
                end
            end
        end
`ifdef SC_EQSCAN_STOP_ON_MATCH_EN
        if (expFound) begin
            expCount    = 1;
            expConsumed = expFirst + 1;
        end
`endif
    endtask

    task automatic applyStimulus(input string tag, input logic [DW-1:0] tgt, input int scanLen,
                                 input int stallMin, input int stallMax,
                                 input bit pokeStart, input bit backToBack);
        bit expFound;
        int expFirst, expCount, expConsumed;
        int cycles, wordIdx, lastAcc, doneCycle, busyCycles, busyErrs, readyErrs, stall;
        bit doneSeen;
        modelScan(tgt, scanLen, expFound, expFirst, expCount, expConsumed);

        bus.SC_EQSCAN_start_In     = 1'b1;
        bus.SC_EQSCAN_target_InBUS = tgt;
        bus.SC_EQSCAN_len_InBUS    = CW'(scanLen);
        @(negedge clk);
        bus.SC_EQSCAN_start_In     = 1'b0;
        bus.SC_EQSCAN_target_InBUS = ~tgt;
        bus.SC_EQSCAN_len_InBUS    = CW'($urandom);

        cycles = 0; wordIdx = 0; lastAcc = -1; doneCycle = -1;
        busyCycles = 0; busyErrs = 0; readyErrs = 0; stall = 0; doneSeen = 1'b0;
        while (!doneSeen && cycles < 400) begin
            if (bus.SC_EQSCAN_busy_Out === 1'b1) busyCycles++;
            else busyErrs++;
            if ((wordIdx < expConsumed) != (bus.SC_EQSCAN_ready_Out === 1'b1)) readyErrs++;
            if (bus.SC_EQSCAN_done_Out === 1'b1) begin
                doneSeen               = 1'b1;
                doneCycle              = cycles;
                bus.SC_EQSCAN_valid_In = 1'b0;
                bus.SC_EQSCAN_start_In = 1'b0;
            end else begin
                if (pokeStart) begin
                    bus.SC_EQSCAN_start_In     = 1'($urandom_range(1, 0));
                    bus.SC_EQSCAN_len_InBUS    = CW'($urandom);
                    bus.SC_EQSCAN_target_InBUS = DW'($urandom);
                end
                if (wordIdx < scanLen && stall == 0) begin
                    bus.SC_EQSCAN_valid_In   = 1'b1;
                    bus.SC_EQSCAN_data_InBUS = stimWords[wordIdx];
                end else begin
                    bus.SC_EQSCAN_valid_In   = 1'b0;
                    bus.SC_EQSCAN_data_InBUS = DW'($urandom);
                    if (stall > 0) stall--;
                end
                if (bus.SC_EQSCAN_valid_In && bus.SC_EQSCAN_ready_Out === 1'b1) begin
                    lastAcc = cycles;
                    wordIdx++;
                    stall = int'($urandom_range(stallMax, stallMin));
                end
                @(negedge clk);
                cycles++;
            end
        end

        checkOutput({tag, ".doneSeen"}, 32'(doneSeen), 32'd1);
        if (scanLen == 0) checkOutput({tag, ".latency"}, doneCycle, 0);
        else              checkOutput({tag, ".latency"}, doneCycle - lastAcc, 2);
        checkOutput({tag, ".consumed"},   wordIdx, expConsumed);
        checkOutput({tag, ".busyErrs"},   busyErrs, 0);
        checkOutput({tag, ".readyErrs"},  readyErrs, 0);
        if (backToBack) checkOutput({tag, ".busyCycles"}, busyCycles, (scanLen == 0) ? 1 : expConsumed + 2);
        checkOutput({tag, ".found"},      32'(bus.SC_EQSCAN_found_Out), 32'(expFound));
        checkOutput({tag, ".firstIdx"},   32'(bus.SC_EQSCAN_firstIdx_OutBUS), expFirst);
        checkOutput({tag, ".matchCount"}, 32'(bus.SC_EQSCAN_matchCount_OutBUS), expCount);
        checkOutput({tag, ".cmpA"},       32'(bus.SC_EQSCAN_cmpA_OutBUS), 32'(tgt));

        @(negedge clk);
        checkOutput({tag, ".donePulse"},  32'(bus.SC_EQSCAN_done_Out), 32'd0);
        checkOutput({tag, ".idleBusy"},   32'(bus.SC_EQSCAN_busy_Out), 32'd0);
        checkOutput({tag, ".holdCount"},  32'(bus.SC_EQSCAN_matchCount_OutBUS), expCount);

        if (!doneSeen) begin
            rstN = 1'b0;
            @(negedge clk);
            rstN = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed no end of test, required finish before 5 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepted;
        int doneCount;
        logic [DW-1:0] tgt;
        int scanLen;
        int stallMax;

        rstN                       = 1'b0;
        bus.SC_EQSCAN_start_In     = 1'b0;
        bus.SC_EQSCAN_target_InBUS = '0;
        bus.SC_EQSCAN_len_InBUS    = '0;
        bus.SC_EQSCAN_valid_In     = 1'b0;
        bus.SC_EQSCAN_data_InBUS   = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        checkOutput("reset.ready",      32'(bus.SC_EQSCAN_ready_Out), 0);
        checkOutput("reset.busy",       32'(bus.SC_EQSCAN_busy_Out), 0);
        checkOutput("reset.done",       32'(bus.SC_EQSCAN_done_Out), 0);
        checkOutput("reset.found",      32'(bus.SC_EQSCAN_found_Out), 0);
        checkOutput("reset.matchCount", 32'(bus.SC_EQSCAN_matchCount_OutBUS), 0);
        checkOutput("reset.cmpA",       32'(bus.SC_EQSCAN_cmpA_OutBUS), 0);
        rstN = 1'b1;
        @(negedge clk);

        // Reset mid-scan after two accepts.
        bus.SC_EQSCAN_start_In     = 1'b1;
        bus.SC_EQSCAN_target_InBUS = 8'h3C;
        bus.SC_EQSCAN_len_InBUS    = 4'd5;
        @(negedge clk);
        bus.SC_EQSCAN_start_In   = 1'b0;
        bus.SC_EQSCAN_valid_In   = 1'b1;
        bus.SC_EQSCAN_data_InBUS = 8'h3C;
        accepted = 0;
        for (int i = 0; i < 2; i++) begin
            if (bus.SC_EQSCAN_ready_Out === 1'b1) accepted++;
            @(negedge clk);
        end
        bus.SC_EQSCAN_valid_In = 1'b0;
        checkOutput("resetMid.accepted", accepted, 2);
        checkOutput("resetMid.preFound", 32'(bus.SC_EQSCAN_found_Out), 1);
        #3 rstN = 1'b0;
        #1;
        checkOutput("resetMid.ready",      32'(bus.SC_EQSCAN_ready_Out), 0);
        checkOutput("resetMid.busy",       32'(bus.SC_EQSCAN_busy_Out), 0);
        checkOutput("resetMid.done",       32'(bus.SC_EQSCAN_done_Out), 0);
        checkOutput("resetMid.found",      32'(bus.SC_EQSCAN_found_Out), 0);
        checkOutput("resetMid.firstIdx",   32'(bus.SC_EQSCAN_firstIdx_OutBUS), 0);
        checkOutput("resetMid.matchCount", 32'(bus.SC_EQSCAN_matchCount_OutBUS), 0);
        checkOutput("resetMid.cmpA",       32'(bus.SC_EQSCAN_cmpA_OutBUS), 0);
        checkOutput("resetMid.cmpB",       32'(bus.SC_EQSCAN_cmpB_OutBUS), 0);
        @(negedge clk);
        rstN = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.SC_EQSCAN_done_Out === 1'b1 || bus.SC_EQSCAN_busy_Out === 1'b1) doneCount++;
        end
        checkOutput("resetMid.noDone", doneCount, 0);

        // Full scan back-to-back.
        stimWords = '{8'h00, 8'hA5, 8'h11, 8'hA5};
        applyStimulus("fullScan", 8'hA5, 4, 0, 0, 1'b0, 1'b1);

        // No match with two idle cycles between words.
        stimWords = '{8'h01, 8'h02, 8'h03};
        applyStimulus("stallNoMatch", 8'h7E, 3, 2, 2, 1'b0, 1'b0);

        // Zero length.
        stimWords = '{};
        applyStimulus("zeroLen", 8'h42, 0, 0, 0, 1'b0, 1'b1);

        // Max length, every word matches, start pulses ignored mid-scan.
        stimWords = '{};
        for (int i = 0; i < 15; i++) stimWords.push_back(8'hFF);
        applyStimulus("maxLen", 8'hFF, 15, 0, 0, 1'b1, 1'b1);

        // Match at index 2 (early stop when the stop-on-match build is used).
        stimWords = '{8'h10, 8'h20, 8'h55, 8'h55, 8'h30, 8'h55};
        applyStimulus("stopMatch", 8'h55, 6, 0, 0, 1'b0, 1'b1);

        // Random scans.
        for (int n = 0; n < 20; n++) begin
            tgt      = DW'($urandom);
            scanLen  = int'($urandom_range(15, 0));
            stallMax = int'($urandom_range(3, 0));
            stimWords = '{};
            for (int i = 0; i < scanLen; i++) begin
                if ($urandom_range(1, 0) == 1) stimWords.push_back(tgt);
                else                           stimWords.push_back(DW'($urandom));
            end
            applyStimulus($sformatf("random%0d", n), tgt, scanLen, 0, stallMax,
                          1'($urandom_range(1, 0)), stallMax == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/sc_equal_scan_ctrl.md
Name: sc_equal_scan_ctrl

Overview:
- Sequencer that time-shares one combinational equality comparator.
- Scans a stream of up to 2^COUNT_WIDTH-1 words against a captured target, one word per cycle over a valid/ready handshake.
- Drives the comparator's two operand buses and samples its result.
- Reports match count, first-match index and a done pulse to the upstream control FSM.

Parameters:
- NUMBER_DATAWIDTH, 8, width of target, stream words and comparator operands.
- COUNT_WIDTH, 4, width of length, index and count fields; max scan length 2^COUNT_WIDTH-1.

Ports:
- SC_EQSCAN_CLOCK_50  in  1  single system clock, rising edge.
- SC_EQSCAN_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_EQSCAN_start_In  in  1  start request, sampled only in IDLE.
- SC_EQSCAN_target_InBUS  in  NUMBER_DATAWIDTH  target word, captured on accepted start.
- SC_EQSCAN_len_InBUS  in  COUNT_WIDTH  number of words to scan, captured on accepted start.
- SC_EQSCAN_valid_In  in  1  stream word valid.
- SC_EQSCAN_data_InBUS  in  NUMBER_DATAWIDTH  stream word.
- SC_EQSCAN_ready_Out  out  1  block accepts a word this cycle.
- SC_EQSCAN_cmpA_OutBUS  out  NUMBER_DATAWIDTH  comparator operand A (registered target).
- SC_EQSCAN_cmpB_OutBUS  out  NUMBER_DATAWIDTH  comparator operand B (registered word).
- SC_EQSCAN_cmpNotEqual_In  in  1  comparator result: 0 = operands equal, 1 = different.
- SC_EQSCAN_busy_Out  out  1  high from accepted start until done pulse inclusive.
- SC_EQSCAN_done_Out  out  1  one-cycle pulse, scan complete.
- SC_EQSCAN_found_Out  out  1  at least one match in last scan.
- SC_EQSCAN_firstIdx_OutBUS  out  COUNT_WIDTH  0-based index of first matching word.
- SC_EQSCAN_matchCount_OutBUS  out  COUNT_WIDTH  number of matching words.

Behaviour:
- Reset (asynchronous, RESET_InLow=0):
  - state=IDLE; all outputs and internal registers 0.
  - Any state returns immediately to IDLE; an in-flight scan is discarded and no done pulse is issued.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - ready=0, busy=0.
  - On start=1: capture target into cmpA and len; clear found, firstIdx, matchCount, index, pending.
  - len==0 -> DONE. Otherwise -> SCAN.
- SCAN:
  - ready=1.
  - Accept occurs when valid&ready: word registered into cmpB, pending set to 1, tagged with current index; index increments.
  - Accept of word index len-1 -> DRAIN (ready=0 from next cycle).
  - start is ignored outside IDLE.
- Evaluation:
  - One cycle after each accept (pending=1), cmpNotEqual_In is sampled.
  - On 0: matchCount increments; if found==0, set found=1 and firstIdx=tagged index.
  - Evaluation of word k and acceptance of word k+1 occur in the same cycle; back-to-back throughput is 1 word/cycle.
  - pending clears when no new accept occurs that cycle.
- DRAIN: evaluate the last pending word; ready=0 -> DONE.
- DONE:
  - done=1 for exactly one cycle; busy=1 -> IDLE.
  - Result outputs hold until the next accepted start.
- Latency: done asserts 2 cycles after the last word is accepted; 1 cycle after start when len==0.
- matchCount cannot overflow: it never exceeds len.
- The stream may stall (valid=0) for any number of cycles in SCAN; the FSM waits indefinitely.

Optional Feature:
- SC_EQSCAN_STOP_ON_MATCH_EN defined:
  - The evaluation cycle that sets found forces ready=0 that same cycle and goes to DONE; no further words are accepted.
  - A word accepted in that cycle is not possible, since ready is combinationally low.
  - matchCount is 1 at done.
- Not defined: the full len words are always consumed, as described above.

Test Plan:
- Reset mid-scan: target=0x3C, len=5, assert RESET_InLow=0 after 2 accepts -> immediately IDLE, all outputs 0, no done pulse.
- Full scan, back-to-back: target=0xA5, len=4, words 0x00,0xA5,0x11,0xA5 with valid held high -> done 2 cycles after 4th accept, found=1, firstIdx=1, matchCount=2, busy high for 6 cycles.
- No match with stalls: target=0x7E, len=3, words 0x01,0x02,0x03 with 2 idle cycles between each -> found=0, matchCount=0, firstIdx=0; ready=1 throughout the stalls.
- Zero length: start with len=0 -> done the next cycle, found=0, matchCount=0; ready never asserts.
- Max length: len=15, all words equal to target 0xFF -> matchCount=15, firstIdx=0, no wrap; start pulses during SCAN are ignored.
- With SC_EQSCAN_STOP_ON_MATCH_EN: target=0x55, len=6, match at index 2 -> ready drops the cycle after the 3rd accept, done follows, matchCount=1, firstIdx=2, words 3..5 not consumed.
